// File: rtl/miriscv_alu_pkg.sv
// Shared ALU definitions: widths, operator codes and the arbiter's response-holding state.
package miriscv_alu_pkg;

  localparam int ALU_OP_WIDTH = 7;
  localparam int DATA_WIDTH   = 32;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 7'b0010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA = 7'b0100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 7'b0100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS = 7'b0000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU = 7'b0000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES = 7'b0001010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 7'b0001011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ  = 7'b0001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE  = 7'b0001101;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/miriscv_alu.sv
// Combinational miriscv ALU; comparisons drive comparison_result_o and a zero-extended copy on result_o.
module miriscv_alu #(
  parameter int DATA_WIDTH   = miriscv_alu_pkg::DATA_WIDTH,
  parameter int ALU_OP_WIDTH = miriscv_alu_pkg::ALU_OP_WIDTH
) (
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    comparison_result_o
);
  import miriscv_alu_pkg::*;

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] arith;

  assign shamt = b_i[SHW-1:0];

  always_comb begin
    arith               = '0;
    comparison_result_o = 1'b0;
    case (operator_i)
      ALU_ADD: arith = a_i + b_i;
      ALU_SUB: arith = a_i - b_i;
      ALU_XOR: arith = a_i ^ b_i;
      ALU_OR:  arith = a_i | b_i;
      ALU_AND: arith = a_i & b_i;
      ALU_SRA: arith = $unsigned($signed(a_i) >>> shamt);
      ALU_SRL: arith = a_i >> shamt;
      ALU_SLL: arith = a_i << shamt;
      ALU_LTS: comparison_result_o = $signed(a_i) < $signed(b_i);
      ALU_LTU: comparison_result_o = a_i < b_i;
      ALU_GES: comparison_result_o = $signed(a_i) >= $signed(b_i);
      ALU_GEU: comparison_result_o = a_i >= b_i;
      ALU_EQ:  comparison_result_o = a_i == b_i;
      ALU_NE:  comparison_result_o = a_i != b_i;
      default: arith = '0;
    endcase
    // Arithmetic ops leave the flag at 0, so OR-ing it in only affects comparisons.
    result_o = arith | {{(DATA_WIDTH-1){1'b0}}, comparison_result_o};
  end

endmodule

// File: rtl/miriscv_alu_arbiter.sv
// Round-robin sharing of one miriscv_alu between two valid/ready requesters,
// with a single held response register returned to the owning port.
module miriscv_alu_arbiter #(
  parameter int DATA_WIDTH   = miriscv_alu_pkg::DATA_WIDTH,
  parameter int ALU_OP_WIDTH = miriscv_alu_pkg::ALU_OP_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*ALU_OP_WIDTH-1:0] req_op_i,
  input  logic [2*DATA_WIDTH-1:0]   req_a_i,
  input  logic [2*DATA_WIDTH-1:0]   req_b_i,
  output logic [1:0]                rsp_valid_o,
  input  logic [1:0]                rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_result_o,
  output logic                      rsp_cmp_o
);
  import miriscv_alu_pkg::*;

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_cmp_q, rsp_cmp_d;

  logic                    free;
  logic                    grant_valid;
  logic                    grant_idx;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_result;
  logic                    alu_cmp;

  // A new grant is allowed whenever the response slot is empty or being emptied this cycle.
  always_comb begin
    free        = (state_q == IDLE) || (rsp_valid_q[owner_q] && rsp_ready_i[owner_q]);
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (!rst_i && free) begin
      case (req_valid_i)
        2'b11: begin grant_valid = 1'b1; grant_idx = rr_ptr_q; end
        2'b01: begin grant_valid = 1'b1; grant_idx = 1'b0;     end
        2'b10: begin grant_valid = 1'b1; grant_idx = 1'b1;     end
        default: begin grant_valid = 1'b0; grant_idx = 1'b0;   end
      endcase
    end
    req_ready_o = 2'b00;
    if (grant_valid) req_ready_o[grant_idx] = 1'b1;
  end

  // grant_idx is 0 without a grant, so the idle ALU simply sees port 0.
  always_comb begin
    alu_op = grant_idx ? req_op_i[ALU_OP_WIDTH +: ALU_OP_WIDTH] : req_op_i[0 +: ALU_OP_WIDTH];
    alu_a  = grant_idx ? req_a_i[DATA_WIDTH +: DATA_WIDTH]      : req_a_i[0 +: DATA_WIDTH];
    alu_b  = grant_idx ? req_b_i[DATA_WIDTH +: DATA_WIDTH]      : req_b_i[0 +: DATA_WIDTH];
  end

  miriscv_alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_alu (
    .operator_i          (alu_op),
    .a_i                 (alu_a),
    .b_i                 (alu_b),
    .result_o            (alu_result),
    .comparison_result_o (alu_cmp)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cmp_d    = rsp_cmp_q;
    if (grant_valid) begin
      state_d      = HOLD;
      owner_d      = grant_idx;
      rr_ptr_d     = ~grant_idx;
      rsp_valid_d  = grant_idx ? 2'b10 : 2'b01;
      rsp_result_d = alu_result;
      rsp_cmp_d    = alu_cmp;
    end else if (state_q == HOLD && rsp_ready_i[owner_q]) begin
      state_d     = IDLE;
      rsp_valid_d = 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_cmp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cmp_q    <= rsp_cmp_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_cmp_o    = rsp_cmp_q;

endmodule

// File: tb/tb_miriscv_alu_arbiter.sv
// Directed and randomized bench for miriscv_alu_arbiter against a transaction-level reference model.
module tb_miriscv_alu_arbiter;
  import miriscv_alu_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int OW = ALU_OP_WIDTH;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [1:0]      req_valid_i = 2'b00;
  logic [1:0]      req_ready_o;
  logic [2*OW-1:0] req_op_i = '0;
  logic [2*DW-1:0] req_a_i = '0;
  logic [2*DW-1:0] req_b_i = '0;
  logic [1:0]      rsp_valid_o;
  logic [1:0]      rsp_ready_i = 2'b00;
  logic [DW-1:0]   rsp_result_o;
  logic            rsp_cmp_o;

  miriscv_alu_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_cmp_o    (rsp_cmp_o)
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model: who holds the slot, whose turn it is on contention, and the held answer.
  bit          mHold   = 1'b0;
  int          mOwner  = 0;
  int          mNext   = 0;
  logic [DW-1:0] mResult = '0;
  logic        mCmp    = 1'b0;
  int          lastGrant = -1;
  logic [1:0]  seenRdy;

  logic [OW-1:0] opList [14] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL,
                                 ALU_SLL, ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE};

  function automatic logic [DW:0] aluModel(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    int     sh = int'(ub % DW);
    bit     flag;
    logic [DW-1:0] r;
    case (op)
      ALU_ADD: return {1'b0, DW'(ua + ub)};
      ALU_SUB: return {1'b0, DW'(ua - ub)};
      ALU_XOR: return {1'b0, a ^ b};
      ALU_OR:  return {1'b0, a | b};
      ALU_AND: return {1'b0, a & b};
      ALU_SRA: begin r = DW'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0)); return {1'b0, r}; end
      ALU_SRL: return {1'b0, DW'(ua / (longint'(1) << sh))};
      ALU_SLL: return {1'b0, DW'(ua * (longint'(1) << sh))};
      ALU_LTS: flag = sa < sb;
      ALU_LTU: flag = ua < ub;
      ALU_GES: flag = sa >= sb;
      ALU_GEU: flag = ua >= ub;
      ALU_EQ:  flag = ua == ub;
      ALU_NE:  flag = ua != ub;
      default: return '0;
    endcase
    return {flag, DW'(flag)};
  endfunction

  task automatic checkOutput(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setPort(int p, bit v, logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    req_valid_i[p]         = v;
    req_op_i[p*OW +: OW]   = op;
    req_a_i[p*DW +: DW]    = a;
    req_b_i[p*DW +: DW]    = b;
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check the response after.
  task automatic applyStimulus(string tag);
    logic [1:0]    expRdy;
    logic [DW:0]   r;
    #1;
    lastGrant = -1;
    if (!rst_i && (!mHold || rsp_ready_i[mOwner])) begin
      if (req_valid_i == 2'b11)  lastGrant = mNext;
      else if (req_valid_i[0])   lastGrant = 0;
      else if (req_valid_i[1])   lastGrant = 1;
    end
    expRdy  = (lastGrant < 0) ? 2'b00 : (2'b01 << lastGrant);
    seenRdy = req_ready_o;
    checkOutput({tag, "_rdy"}, DW'(req_ready_o), DW'(expRdy));
    @(posedge clk_i);
    if (rst_i) begin
      mHold = 0; mOwner = 0; mNext = 0; mResult = '0; mCmp = 1'b0;
    end else if (lastGrant >= 0) begin
      r       = aluModel(req_op_i[lastGrant*OW +: OW], req_a_i[lastGrant*DW +: DW], req_b_i[lastGrant*DW +: DW]);
      mResult = r[DW-1:0];
      mCmp    = r[DW];
      mOwner  = lastGrant;
      mNext   = 1 - lastGrant;
      mHold   = 1;
    end else if (mHold && rsp_ready_i[mOwner]) begin
      mHold = 0;
    end
    #1;
    checkOutput({tag, "_vld"}, DW'(rsp_valid_o), mHold ? DW'(2'b01 << mOwner) : '0);
    checkOutput({tag, "_res"}, rsp_result_o, mResult);
    checkOutput({tag, "_cmp"}, DW'(rsp_cmp_o), DW'(mCmp));
  endtask

  initial begin
    bit            pend [2];
    logic [OW-1:0] op;

    // Reset with both ports requesting.
    @(negedge clk_i);
    rst_i = 1'b1; rsp_ready_i = 2'b11;
    setPort(0, 1, ALU_ADD, 32'd1, 32'd1);
    setPort(1, 1, ALU_ADD, 32'd2, 32'd2);
    applyStimulus("t1_rst_a");
    @(negedge clk_i); applyStimulus("t1_rst_b");
    checkOutput("t1_rst_result", rsp_result_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    applyStimulus("t1_first");
    checkOutput("t1_first_grant", DW'(seenRdy), DW'(2'b01));
    @(negedge clk_i); setPort(0, 0, ALU_ADD, 0, 0); setPort(1, 0, ALU_ADD, 0, 0);
    applyStimulus("t1_drain");

    // Single requester on port 1.
    @(negedge clk_i); setPort(1, 1, ALU_ADD, 32'd5, 32'd7);
    applyStimulus("t2_add");
    checkOutput("t2_add_grant", DW'(seenRdy), DW'(2'b10));
    checkOutput("t2_add_const", rsp_result_o, 32'd12);
    @(negedge clk_i); setPort(1, 1, ALU_SUB, 32'd0, 32'd1);
    applyStimulus("t2_sub");
    checkOutput("t2_sub_const", rsp_result_o, 32'hFFFF_FFFF);
    @(negedge clk_i); setPort(1, 0, ALU_SUB, 0, 0);
    applyStimulus("t2_drain");

    // Continuous contention alternates grants.
    @(negedge clk_i);
    setPort(0, 1, ALU_LTS, 32'hFFFF_FFFF, 32'd1);
    setPort(1, 1, ALU_GEU, 32'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("t3_cont%0d", i));
      checkOutput($sformatf("t3_alt%0d", i), DW'(seenRdy), (i % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      checkOutput($sformatf("t3_res%0d", i), rsp_result_o, (i % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk_i);
    end
    setPort(0, 0, ALU_LTS, 0, 0); setPort(1, 0, ALU_GEU, 0, 0);
    applyStimulus("t3_drain");

    // Response backpressure on port 0 stalls port 1.
    @(negedge clk_i);
    rsp_ready_i = 2'b10;
    setPort(0, 1, ALU_XOR, 32'hFFFF_FFFF, 32'd1);
    setPort(1, 1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    applyStimulus("t4_grant");
    @(negedge clk_i); setPort(0, 0, ALU_XOR, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("t4_stall%0d", i));
      checkOutput($sformatf("t4_stall_rdy%0d", i), DW'(seenRdy), DW'(2'b00));
      checkOutput($sformatf("t4_held%0d", i), rsp_result_o, 32'hFFFF_FFFE);
      @(negedge clk_i);
    end
    rsp_ready_i = 2'b11;
    applyStimulus("t4_release");
    checkOutput("t4_release_grant", DW'(seenRdy), DW'(2'b10));
    @(negedge clk_i); setPort(1, 0, ALU_AND, 0, 0);
    applyStimulus("t4_drain");

    // Reset while a response is held.
    @(negedge clk_i); rsp_ready_i = 2'b00; setPort(0, 1, ALU_SLL, 32'd1, 32'd1);
    applyStimulus("t5_grant");
    @(negedge clk_i); setPort(0, 0, ALU_SLL, 0, 0);
    applyStimulus("t5_held");
    @(negedge clk_i); rst_i = 1'b1;
    applyStimulus("t5_rst");
    checkOutput("t5_rst_vld", DW'(rsp_valid_o), '0);
    @(negedge clk_i); rst_i = 1'b0; rsp_ready_i = 2'b11;
    setPort(0, 1, ALU_OR, 32'h10, 32'h01); setPort(1, 1, ALU_SRL, 32'h80, 32'd3);
    applyStimulus("t5_after");
    checkOutput("t5_after_grant", DW'(seenRdy), DW'(2'b01));
    @(negedge clk_i); setPort(0, 0, ALU_OR, 0, 0); setPort(1, 0, ALU_SRL, 0, 0);
    applyStimulus("t5_drain");

    // Accept and new grant in the same cycle.
    @(negedge clk_i); setPort(0, 1, ALU_EQ, 32'd3, 32'd3);
    applyStimulus("t6_eq");
    @(negedge clk_i); setPort(0, 0, ALU_EQ, 0, 0); setPort(1, 1, ALU_NE, 32'd3, 32'd4);
    applyStimulus("t6_ne");
    checkOutput("t6_ne_vld", DW'(rsp_valid_o), DW'(2'b10));
    checkOutput("t6_ne_res", rsp_result_o, 32'd1);
    @(negedge clk_i); setPort(1, 0, ALU_NE, 0, 0);
    applyStimulus("t6_drain");

    // Randomized traffic: requests stay valid and stable until accepted.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      rst_i       = ($urandom_range(0, 99) < 2);
      rsp_ready_i = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 60) begin
          op = ($urandom_range(0, 9) == 0) ? OW'($urandom) : opList[$urandom_range(0, 13)];
          setPort(p, 1, op, ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom);
          pend[p] = 1;
        end
      end
      applyStimulus($sformatf("rnd%0d", c));
      if (lastGrant >= 0) begin
        pend[lastGrant] = 0;
        req_valid_i[lastGrant] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
